// File: rtl/serial_tx_sched_if.sv
// rtl/serial_tx_sched_if.sv - requester and serial-line bundle for serial_tx_sched
interface serial_tx_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic                      ser_data_out;
    logic                      busy;
    logic                      done;
    logic [ID_W-1:0]           cur_id;

    modport master (
        output req, req_data,
        input  ack, ser_data_out, busy, done, cur_id
    );

    modport slave (
        input  req, req_data,
        output ack, ser_data_out, busy, done, cur_id
    );
endinterface

// File: rtl/serial_tx_sched.sv
// rtl/serial_tx_sched.sv - round-robin byte scheduler driving one 8N1 serial line
module serial_tx_sched #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 8,
    parameter int BAUD_DIV = 256
) (
    input logic               clk,
    input logic               rst,
    serial_tx_sched_if.slave  bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [ID_W-1:0]  PTR_INIT  = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t             r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [CNT_W-1:0]   r_baud_cnt;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [DATA_W-1:0]  r_shift;
    logic               r_ser;
    logic               r_busy;
    logic               r_done;
    logic [NUM_REQ-1:0] r_ack;
    logic [ID_W-1:0]    r_cur_id;

    logic               w_grant_vld;
    logic [ID_W-1:0]    w_grant_idx;
    logic               w_baud_wrap;

    assign w_baud_wrap = (r_baud_cnt == BAUD_LAST);

    // Scan from farthest to nearest so the nearest set index after r_ptr wins.
    always_comb begin
        int idx;
        idx         = 0;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(r_ptr) + k) % NUM_REQ;
            if (bus.req[idx]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= PTR_INIT;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_ser      <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ack      <= '0;
            r_cur_id   <= '0;
        end else begin
            r_ack  <= '0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ser      <= 1'b1;
                    r_busy     <= 1'b0;
                    r_baud_cnt <= '0;
                    r_bit_cnt  <= '0;
                    if (w_grant_vld) begin
                        r_shift              <= bus.req_data[w_grant_idx*DATA_W +: DATA_W];
                        r_ack[w_grant_idx]   <= 1'b1;
                        r_cur_id             <= w_grant_idx;
                        r_ptr                <= w_grant_idx;
                        r_busy               <= 1'b1;
                        r_ser                <= 1'b0;
                        r_state              <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_wrap) begin
                        r_baud_cnt <= '0;
                        r_ser      <= r_shift[0];
                        r_shift    <= r_shift >> 1;
                        r_state    <= S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_wrap) begin
                        r_baud_cnt <= '0;
                        if (r_bit_cnt == BIT_LAST) begin
                            r_ser   <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_ser     <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_baud_wrap) begin
                        r_baud_cnt <= '0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ack          = r_ack;
    assign bus.ser_data_out = r_ser;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.cur_id       = r_cur_id;
endmodule

// File: tb/tb_serial_tx_sched.sv
// tb/tb_serial_tx_sched.sv - scoreboard bench for serial_tx_sched at BAUD_DIV 4 and 2
module tb_serial_tx_sched;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_tx_sched_if #(.NUM_REQ(4), .DATA_W(8)) if4 ();
    serial_tx_sched_if #(.NUM_REQ(4), .DATA_W(8)) if2 ();

    serial_tx_sched #(.NUM_REQ(4), .DATA_W(8), .BAUD_DIV(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    serial_tx_sched #(.NUM_REQ(4), .DATA_W(8), .BAUD_DIV(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    typedef struct {
        int         id;
        logic [7:0] data;
        bit         abort;
    } exp_t;

    exp_t q4[$];
    exp_t q2[$];

    logic [3:0] m_ack  [2];
    logic       m_ser  [2];
    logic       m_busy [2];
    logic       m_done [2];
    logic [1:0] m_cur  [2];

    assign m_ack[0]  = if4.ack;
    assign m_ack[1]  = if2.ack;
    assign m_ser[0]  = if4.ser_data_out;
    assign m_ser[1]  = if2.ser_data_out;
    assign m_busy[0] = if4.busy;
    assign m_busy[1] = if2.busy;
    assign m_done[0] = if4.done;
    assign m_done[1] = if2.done;
    assign m_cur[0]  = if4.cur_id;
    assign m_cur[1]  = if2.cur_id;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic int qsize(input int u);
        return (u == 0) ? q4.size() : q2.size();
    endfunction

    function automatic exp_t qpop(input int u);
        if (u == 0) return q4.pop_front();
        return q2.pop_front();
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: each ack starts a frame; every bit cell and the closing done are checked.
    task automatic mon(input int u, input int b);
        exp_t       e;
        logic [9:0] fr;
        logic [3:0] exp_ack;
        logic       obs;
        bit         ctl_bad;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (m_ack[u] != 4'h0) begin
                if (qsize(u) == 0) begin
                    chk($sformatf("u%0d_unexpected_ack", u), 32'(m_ack[u]), 32'h0);
                end else begin
                    e       = qpop(u);
                    exp_ack = 4'h0;
                    exp_ack[e.id] = 1'b1;
                    chk($sformatf("u%0d_ack", u), 32'(m_ack[u]), 32'(exp_ack));
                    chk($sformatf("u%0d_cur_id_grant", u), 32'(m_cur[u]), 32'(e.id));
                    fr      = {1'b1, e.data, 1'b0};
                    aborted = 1'b0;
                    for (int k = 0; k < 10; k++) begin
                        obs     = fr[k];
                        ctl_bad = 1'b0;
                        for (int c = 0; c < b; c++) begin
                            if (k > 0 || c > 0) @(negedge clk);
                            if (!rst) begin
                                aborted = 1'b1;
                                break;
                            end
                            if (m_ser[u] !== fr[k]) obs = m_ser[u];
                            if (m_busy[u] !== 1'b1 || m_done[u] !== 1'b0) ctl_bad = 1'b1;
                        end
                        if (aborted) break;
                        chk($sformatf("u%0d_id%0d_bit%0d", u, e.id, k), 32'(obs), 32'(fr[k]));
                        chk($sformatf("u%0d_id%0d_ctl%0d", u, e.id, k), 32'(ctl_bad), 32'h0);
                    end
                    chk($sformatf("u%0d_abort_expected", u), 32'(aborted), 32'(e.abort));
                    @(negedge clk);
                    if (aborted) begin
                        chk($sformatf("u%0d_rst_ser", u), 32'(m_ser[u]), 32'h1);
                        chk($sformatf("u%0d_rst_busy", u), 32'(m_busy[u]), 32'h0);
                        chk($sformatf("u%0d_rst_done", u), 32'(m_done[u]), 32'h0);
                    end else begin
                        chk($sformatf("u%0d_done", u), 32'(m_done[u]), 32'h1);
                        chk($sformatf("u%0d_end_busy", u), 32'(m_busy[u]), 32'h0);
                        chk($sformatf("u%0d_end_ser", u), 32'(m_ser[u]), 32'h1);
                        chk($sformatf("u%0d_cur_id_hold", u), 32'(m_cur[u]), 32'(e.id));
                    end
                end
            end
        end
    endtask

    initial mon(0, 4);
    initial mon(1, 2);

    task automatic push4(input int id, input logic [7:0] d, input bit ab);
        exp_t e;
        e.id = id; e.data = d; e.abort = ab;
        q4.push_back(e);
    endtask

    task automatic wait_idle(input int u);
        int t = 0;
        while ((qsize(u) != 0 || m_busy[u] !== 1'b0) && t < 2000) begin
            cyc(1);
            t++;
        end
        chk($sformatf("u%0d_idle_timeout", u), 32'(t >= 2000), 32'h0);
        cyc(2);
    endtask

    task automatic hold_acks(input int n);
        int k = 0;
        int t = 0;
        while (k < n && t < 2000) begin
            cyc(1);
            t++;
            if (if4.ack != 4'h0) k++;
        end
        chk("ack_count_timeout", 32'(k), 32'(n));
    endtask

    task automatic rst_pulse();
        rst = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(1);
    endtask

    initial begin
        exp_t e2;
        if4.req = '0; if4.req_data = '0;
        if2.req = '0; if2.req_data = '0;
        cyc(2);
        chk("rst_ser4",  32'(if4.ser_data_out), 32'h1);
        chk("rst_busy4", 32'(if4.busy), 32'h0);
        chk("rst_done4", 32'(if4.done), 32'h0);
        chk("rst_ack4",  32'(if4.ack), 32'h0);
        chk("rst_cur4",  32'(if4.cur_id), 32'h0);
        chk("rst_ser2",  32'(if2.ser_data_out), 32'h1);
        rst = 1'b1;
        cyc(2);

        // single 0xA5 frame from requester 0
        if4.req_data[7:0] = 8'hA5;
        push4(0, 8'hA5, 1'b0);
        if4.req = 4'b0001;
        cyc(1);
        if4.req = 4'b0000;
        wait_idle(0);

        // all requesters held: 0,1,2,3,0 with one idle cycle between frames
        rst_pulse();
        if4.req_data = {8'h81, 8'h3C, 8'h22, 8'h11};
        push4(0, 8'h11, 1'b0); push4(1, 8'h22, 1'b0); push4(2, 8'h3C, 1'b0);
        push4(3, 8'h81, 1'b0); push4(0, 8'h11, 1'b0);
        if4.req = 4'b1111;
        begin
            int n = 0;
            int t = 0;
            int last = 0;
            while (n < 5 && t < 2000) begin
                cyc(1);
                t++;
                if (if4.ack != 4'h0) begin
                    if (n > 0) chk($sformatf("rr_gap%0d", n), 32'(t - last), 32'd41);
                    last = t;
                    n++;
                end
            end
            chk("rr_ack_count", 32'(n), 32'd5);
        end
        if4.req = 4'b0000;
        wait_idle(0);

        // req2 alone, then req1+req2: pointer 2 serves 1 before 2
        rst_pulse();
        if4.req_data = {8'h00, 8'h5A, 8'h96, 8'h00};
        push4(2, 8'h5A, 1'b0);
        if4.req = 4'b0100;
        hold_acks(1);
        if4.req = 4'b0000;
        wait_idle(0);
        push4(1, 8'h96, 1'b0); push4(2, 8'h5A, 1'b0);
        if4.req = 4'b0110;
        hold_acks(2);
        if4.req = 4'b0000;
        wait_idle(0);

        // reset during data bit 3 aborts the frame without retry
        rst_pulse();
        if4.req_data = {8'hC3, 24'h0};
        push4(3, 8'hC3, 1'b1);
        if4.req = 4'b1000;
        cyc(1);
        if4.req = 4'b0000;
        cyc(17);
        rst = 1'b0;
        cyc(2);
        chk("abort_ser",  32'(if4.ser_data_out), 32'h1);
        chk("abort_busy", 32'(if4.busy), 32'h0);
        chk("abort_done", 32'(if4.done), 32'h0);
        chk("abort_cur",  32'(if4.cur_id), 32'h0);
        rst = 1'b1;
        cyc(8);
        chk("abort_no_retry", 32'(if4.busy), 32'h0);
        if4.req_data = {8'hE7, 24'h0};
        push4(3, 8'hE7, 1'b0);
        if4.req = 4'b1000;
        cyc(1);
        if4.req = 4'b0000;
        wait_idle(0);

        // 0x00 frame; a one-cycle req2 pulse mid-frame must be ignored
        if4.req_data = 32'h0;
        push4(0, 8'h00, 1'b0);
        if4.req = 4'b0001;
        cyc(1);
        if4.req = 4'b0000;
        cyc(10);
        if4.req_data[23:16] = 8'h77;
        if4.req = 4'b0100;
        cyc(1);
        if4.req = 4'b0000;
        wait_idle(0);
        cyc(5);

        // BAUD_DIV=2 with 0xFF
        if2.req_data[7:0] = 8'hFF;
        e2.id = 0; e2.data = 8'hFF; e2.abort = 1'b0;
        q2.push_back(e2);
        if2.req = 4'b0001;
        cyc(1);
        if2.req = 4'b0000;
        wait_idle(1);

        chk("q4_drained", 32'(q4.size()), 32'h0);
        chk("q2_drained", 32'(q2.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
